keccak_msg_padder: RTL
======================

Name: keccak_msg_padder

Overview:
- Streaming pad10*1 stage between the byte-counted message input and the Keccak absorb/permutation core.
- Accepts 64-bit little-endian message words plus a total byte length. Emits rate-sized blocks of RATE_LANES lanes with the domain suffix and final 0x80 bit inserted.
- Tracks remaining bytes and lane position. Flags block and message ends for the absorb logic.

Parameters:
- W, 64, lane width in bits (fixed to 64; byte math assumes 8 bytes/lane)
- RATE_LANES, 17, lanes per rate block (17 = SHA3-256, 1088-bit rate)
- LEN_WIDTH, 32, width of message byte-length input
- DS, 8'h06, domain-separation suffix byte (SHA3)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin message; sampled only when busy=0
- msg_len  in  LEN_WIDTH  total message length in bytes, captured on start
- in_data  in  64  message word; byte k in bits [8k+7:8k]
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- out_lane  out  64  padded lane
- out_valid  out  1  out_lane valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_lane_idx  out  5  lane index within block, 0..RATE_LANES-1
- out_block_last  out  1  out_lane is lane RATE_LANES-1
- out_msg_last  out  1  out_lane is final lane of final block
- busy  out  1  message in progress (start ignored)

Behaviour:
- Reset: out_valid=0, in_ready=0, busy=0, out_lane=0, out_lane_idx=0, out_block_last=0, out_msg_last=0. FSM goes to IDLE. Counters are cleared. Reset mid-message abandons the message; no further lanes are emitted.
- FSM states: IDLE, DATA, PAD.
  - IDLE: on start, capture rem=msg_len, lane_cnt=0, pad_done=0, busy=1. If msg_len=0, go to PAD; otherwise go to DATA.
  - DATA: needs one input word per lane. Leave when rem reaches 0 after a consume.
  - PAD: generates lanes without input until the lane with lane_cnt=RATE_LANES-1 is emitted, then go to IDLE and set busy=0.
- Output register: single entry. A new lane is loaded when !out_valid || out_ready.
  - in_ready = (state==DATA) && (!out_valid || out_ready).
  - Latency from input accept to out_valid is 1 cycle.
  - PAD lanes are produced at 1 lane/cycle under no backpressure.
- Lane formation (r = rem at lane generation):
  - r>=8: lane = in_data; rem -= 8.
  - 0<r<8 (DATA): low r bytes from in_data; byte r = DS; higher bytes = 0; bytes of in_data above r are ignored. Set pad_done=1, rem=0, go to PAD.
  - r=0, pad_done=0: lane byte0 = DS, rest 0; set pad_done=1.
  - r=0, pad_done=1: lane = 0.
  - If r>=8 makes rem=0 exactly, go to PAD with pad_done=0. The next lane carries DS, which starts a new block if lane_cnt wrapped.
- Final bit: on the lane with lane_cnt=RATE_LANES-1 in PAD where pad_done is already set, or is set by this lane, OR 0x80 into byte 7 (bit 63). DS and 0x80 in the same byte give 0x86. That lane sets out_block_last=1 and out_msg_last=1.
- lane_cnt wraps RATE_LANES-1 -> 0. out_block_last=1 on every lane with index RATE_LANES-1.
- Block count = floor(msg_len/(8*RATE_LANES)) + 1. A message that is an exact multiple of the rate gets one extra all-padding block.
- Simultaneous start while busy: ignored. in_valid outside DATA: ignored; in_ready stays 0.
- Widths: rem is LEN_WIDTH bits; the subtraction never underflows (guarded by r>=8).

Optional Feature:
- Macro KECCAK_PAD_RUNTIME_DS_EN.
- Defined: adds input port ds_in [7:0], captured on start and used in place of the DS parameter for that message (e.g. 8'h1F for SHAKE).
- Undefined: no ds_in port; parameter DS is always used.

Test Plan:
- msg_len=0, out_ready=1 -> 17 lanes: lane0=64'h06, lanes1..15=0, lane16=64'h8000_0000_0000_0000 with out_block_last=out_msg_last=1; busy drops the cycle after.
- msg_len=3, in_data=64'hFFFF_FFFF_FFCC_BBAA -> lane0=64'h0000_0000_06CC_BBAA; lanes1..15=0; lane16=64'h8000_0000_0000_0000.
- msg_len=135, 17 words of 64'h1111_1111_1111_1111 -> lanes0..15 = input; lane16=64'h8611_1111_1111_1111, out_msg_last=1.
- msg_len=136, 17 full words -> block0 lanes = input, lane16 out_block_last=1, out_msg_last=0. Block1: lane0=64'h06, lane16=64'h8000_0000_0000_0000 with out_msg_last=1; 34 lanes total.
- msg_len=20 with out_ready toggling 1,0,0,1 and in_valid gaps -> no lane lost or duplicated; out_lane stable while out_valid && !out_ready; lane2=64'h0000_0006_DDCC_BBAA for last data bytes AA..DD.
- rst asserted after 5 lanes of msg_len=200 -> out_valid=0, busy=0 immediately; new start with msg_len=0 yields the correct 17-lane padding block.

Source files
------------

// File: rtl/keccak_msg_padder.sv
// Streaming pad10*1 stage: turns a byte-counted stream of 64-bit words into rate-sized blocks.
// Optional macro KECCAK_PAD_RUNTIME_DS_EN adds a per-message ds_in suffix port.
module keccak_msg_padder #(
  parameter int unsigned W          = 64,
  parameter int unsigned RATE_LANES = 17,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter logic [7:0]  DS         = 8'h06
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] msg_len,
`ifdef KECCAK_PAD_RUNTIME_DS_EN
  input  logic [7:0]           ds_in,
`endif
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         out_lane,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_lane_idx,
  output logic                 out_block_last,
  output logic                 out_msg_last,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StData, StPad} state_e;

  localparam logic [4:0]           LastLane  = 5'(RATE_LANES - 1);
  localparam logic [LEN_WIDTH-1:0] LaneBytes = LEN_WIDTH'(8);

  state_e               st_q, st_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [4:0]           lane_cnt_q, lane_cnt_d;
  logic                 pad_done_q, pad_done_d;

  logic [W-1:0]         out_lane_q, out_lane_d;
  logic                 out_valid_q, out_valid_d;
  logic [4:0]           out_idx_q, out_idx_d;
  logic                 out_bl_q, out_bl_d;
  logic                 out_ml_q, out_ml_d;

  logic                 load, gen, fin, last_lane;
  logic [W-1:0]         lane;
  logic [7:0]           ds_cur;

`ifdef KECCAK_PAD_RUNTIME_DS_EN
  logic [7:0] ds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_q <= DS;
    end else if (st_q == StIdle && start) begin
      ds_q <= ds_in;
    end
  end

  assign ds_cur = ds_q;
`else
  assign ds_cur = DS;
`endif

  always_comb begin
    st_d        = st_q;
    rem_d       = rem_q;
    lane_cnt_d  = lane_cnt_q;
    pad_done_d  = pad_done_q;
    out_lane_d  = out_lane_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_bl_d    = out_bl_q;
    out_ml_d    = out_ml_q;
    lane        = '0;
    gen         = 1'b0;
    fin         = 1'b0;

    // The single output slot is free when empty or being drained this cycle.
    load      = !out_valid_q || out_ready;
    in_ready  = (st_q == StData) && load;
    last_lane = (lane_cnt_q == LastLane);

    if (load) begin
      out_valid_d = 1'b0;
    end

    unique case (st_q)
      StIdle: begin
        if (start) begin
          rem_d      = msg_len;
          lane_cnt_d = '0;
          pad_done_d = 1'b0;
          st_d       = (msg_len == '0) ? StPad : StData;
        end
      end
      StData: begin
        if (in_ready && in_valid) begin
          gen = 1'b1;
          if (rem_q >= LaneBytes) begin
            lane  = in_data;
            rem_d = rem_q - LaneBytes;
            if (rem_d == '0) begin
              st_d = StPad;
            end
          end else begin
            // Tail word: keep the valid bytes, suffix right after them, drop the rest.
            for (int k = 0; k < 8; k++) begin
              if (rem_q > LEN_WIDTH'(k)) begin
                lane[8*k +: 8] = in_data[8*k +: 8];
              end else if (rem_q == LEN_WIDTH'(k)) begin
                lane[8*k +: 8] = ds_cur;
              end
            end
            pad_done_d = 1'b1;
            rem_d      = '0;
            st_d       = StPad;
            fin        = last_lane;
          end
        end
      end
      StPad: begin
        if (load) begin
          gen = 1'b1;
          if (!pad_done_q) begin
            lane[7:0]  = ds_cur;
            pad_done_d = 1'b1;
          end
          fin = last_lane;
        end
      end
      default: st_d = StIdle;
    endcase

    if (fin) begin
      lane[W-1 -: 8] = lane[W-1 -: 8] | 8'h80;
      st_d           = StIdle;
    end

    if (gen) begin
      out_lane_d  = lane;
      out_valid_d = 1'b1;
      out_idx_d   = lane_cnt_q;
      out_bl_d    = last_lane;
      out_ml_d    = fin;
      lane_cnt_d  = last_lane ? 5'd0 : lane_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= StIdle;
      rem_q       <= '0;
      lane_cnt_q  <= '0;
      pad_done_q  <= 1'b0;
      out_lane_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_bl_q    <= 1'b0;
      out_ml_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      rem_q       <= rem_d;
      lane_cnt_q  <= lane_cnt_d;
      pad_done_q  <= pad_done_d;
      out_lane_q  <= out_lane_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_bl_q    <= out_bl_d;
      out_ml_q    <= out_ml_d;
    end
  end

  assign out_lane       = out_lane_q;
  assign out_valid      = out_valid_q;
  assign out_lane_idx   = out_idx_q;
  assign out_block_last = out_bl_q;
  assign out_msg_last   = out_ml_q;
  assign busy           = (st_q != StIdle);

endmodule
